// File: rtl/lsu_request_dispatcher.sv
// lsu_request_dispatcher: accepts core memory ops, allocates LSU tags, drives
// the two-phase LSU instr/data handshake and returns completions to the core
// in completion order through a response FIFO.
module lsu_request_dispatcher #(
  parameter int TAG_WIDTH    = 10,
  parameter int ID_WIDTH     = 8,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              core_req_valid_in,
  output logic                              core_req_ready_out,
  input  logic                              core_req_is_write_in,
  input  logic [ID_WIDTH-1:0]               core_req_id_in,
  input  logic [63:0]                       core_req_addr_in,
  input  logic [63:0]                       core_req_value_in,
  output logic                              proc_instr_valid_out,
  input  logic                              proc_instr_ready_in,
  output logic [TAG_WIDTH-1:0]              proc_instr_tag_out,
  output logic                              proc_instr_is_write_out,
  output logic                              proc_data_valid_out,
  input  logic                              proc_data_ready_in,
  output logic [TAG_WIDTH-1:0]              proc_data_tag_out,
  output logic [63:0]                       proc_addr_out,
  output logic [63:0]                       proc_value_out,
  input  logic                              completion_valid_in,
  input  logic [TAG_WIDTH-1:0]              completion_tag_in,
  input  logic [63:0]                       completion_value_in,
  output logic                              core_resp_valid_out,
  input  logic                              core_resp_ready_in,
  output logic [ID_WIDTH-1:0]               core_resp_id_out,
  output logic                              core_resp_is_write_out,
  output logic [63:0]                       core_resp_value_out,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight_count_out,
  output logic                              tag_error_out
);

  localparam int SLOT_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W  = $clog2(MAX_INFLIGHT) + 1;

  typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

  state_t state;

  // Slot table
  logic [MAX_INFLIGHT-1:0] busy;
  logic [ID_WIDTH-1:0]     slot_id [MAX_INFLIGHT];
  logic                    slot_wr [MAX_INFLIGHT];

  // Response FIFO
  logic [ID_WIDTH-1:0]     fifo_id  [MAX_INFLIGHT];
  logic                    fifo_wr  [MAX_INFLIGHT];
  logic [63:0]             fifo_val [MAX_INFLIGHT];
  logic [SLOT_W-1:0]       wr_ptr;
  logic [SLOT_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]        fifo_cnt;

  logic              accept;
  logic              pop;
  logic              cmpl_hit;
  logic [SLOT_W-1:0] cmpl_slot;
  logic [SLOT_W-1:0] free_idx;
  logic              free_found;

  assign core_req_ready_out  = (state == IDLE) && (inflight_count_out < CNT_W'(MAX_INFLIGHT));
  assign accept              = core_req_valid_in && core_req_ready_out;
  assign core_resp_valid_out = (fifo_cnt != '0);
  assign pop                 = core_resp_valid_out && core_resp_ready_in;

  assign cmpl_slot = completion_tag_in[SLOT_W-1:0];
  assign cmpl_hit  = completion_valid_in
                   && (completion_tag_in < TAG_WIDTH'(MAX_INFLIGHT))
                   && busy[cmpl_slot];

  // Head fields are masked so the outputs read 0 whenever the FIFO is empty.
  assign core_resp_id_out       = core_resp_valid_out ? fifo_id[rd_ptr]  : '0;
  assign core_resp_is_write_out = core_resp_valid_out ? fifo_wr[rd_ptr]  : 1'b0;
  assign core_resp_value_out    = core_resp_valid_out ? fifo_val[rd_ptr] : '0;

  // Lowest-index free slot from the registered busy vector.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
      if (!busy[i] && !free_found) begin
        free_idx   = SLOT_W'(i);
        free_found = 1'b1;
      end
    end
  end

  // Request FSM: IDLE -> INSTR -> DATA -> IDLE with registered LSU outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                   <= IDLE;
      proc_instr_valid_out    <= 1'b0;
      proc_instr_tag_out      <= '0;
      proc_instr_is_write_out <= 1'b0;
      proc_data_valid_out     <= 1'b0;
      proc_data_tag_out       <= '0;
      proc_addr_out           <= '0;
      proc_value_out          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state                   <= INSTR;
            proc_instr_valid_out    <= 1'b1;
            proc_instr_tag_out      <= TAG_WIDTH'(free_idx);
            proc_instr_is_write_out <= core_req_is_write_in;
            proc_data_tag_out       <= TAG_WIDTH'(free_idx);
            proc_addr_out           <= core_req_addr_in;
            proc_value_out          <= core_req_value_in;
          end
        end
        INSTR: begin
          if (proc_instr_ready_in) begin
            state                <= DATA;
            proc_instr_valid_out <= 1'b0;
            proc_data_valid_out  <= 1'b1;
          end
        end
        DATA: begin
          if (proc_data_ready_in) begin
            state               <= IDLE;
            proc_data_valid_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slot table: allocate on accept, free on a valid completion. The two never
  // target the same slot because allocation only picks non-busy slots.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
    end else begin
      if (cmpl_hit) busy[cmpl_slot] <= 1'b0;
      if (accept) begin
        busy[free_idx]    <= 1'b1;
        slot_id[free_idx] <= core_req_id_in;
        slot_wr[free_idx] <= core_req_is_write_in;
      end
    end
  end

  // Response FIFO; credit accounting guarantees it never overflows.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (cmpl_hit) begin
        fifo_id[wr_ptr]  <= slot_id[cmpl_slot];
        fifo_wr[wr_ptr]  <= slot_wr[cmpl_slot];
        fifo_val[wr_ptr] <= completion_value_in;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({cmpl_hit, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credit counter (busy slots plus queued responses) and sticky tag error.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      inflight_count_out <= '0;
      tag_error_out      <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10:   inflight_count_out <= inflight_count_out + 1'b1;
        2'b01:   inflight_count_out <= inflight_count_out - 1'b1;
        default: inflight_count_out <= inflight_count_out;
      endcase
      if (completion_valid_in && !cmpl_hit) tag_error_out <= 1'b1;
    end
  end

endmodule
